// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between fetch and decode.
//
// Buffers up to DEPTH {pc, instr, exc} entries captured from fetch and
// presents the oldest one to decode. pc_stall holds fetch's PC whenever
// the queue cannot take a word, so no fetched word is lost or duplicated.
// A flush (fetch's absJump strobe) empties the queue in one cycle.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   f_valid            fetch word valid this cycle (not hanging)
//   f_pc, f_instr      fetch PC and instruction word
//   f_exc              fetch address exception for f_pc
//   flush              redirect this cycle
//   pc_stall           to fetch: hold the PC
//   d_valid            head entry valid for decode
//   d_pc, d_instr      head entry PC and instruction (0 when !d_valid)
//   d_exc              head entry exception flag (0 when !d_valid)
//   d_ready            decode accepts the head this cycle
//   count              current occupancy, 0..DEPTH
//
// Handshakes: an entry moves fetch->queue on a clock edge where
// f_valid && !pc_stall && !flush, and queue->decode on an edge where
// d_valid && d_ready. pc_stall depends only on state and flush, never on
// d_ready, so a full queue refuses a push even in a cycle that pops.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_valid,
  input  logic [31:0]              f_pc,
  input  logic [31:0]              f_instr,
  input  logic                     f_exc,
  input  logic                     flush,
  output logic                     pc_stall,
  output logic                     d_valid,
  output logic [31:0]              d_pc,
  output logic [31:0]              d_instr,
  output logic                     d_exc,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Entry layout: {exc, pc, instr}
  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          exc_hold;
  logic          push;
  logic          pop;
  logic [64:0]   head;

  // Stall is dropped during a flush: fetch gives pcStall priority over
  // absJump, so a stall here would swallow the redirect.
  assign pc_stall = !flush && ((count == FULL_CNT) || exc_hold);
  assign push     = f_valid && !pc_stall && !flush;
  assign d_valid  = (count != '0) && !flush;
  assign pop      = d_valid && d_ready;

  assign head    = mem[rd_ptr];
  assign d_exc   = d_valid ? head[64]    : 1'b0;
  assign d_pc    = d_valid ? head[63:32] : 32'h0;
  assign d_instr = d_valid ? head[31:0]  : 32'h0;

  // Storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {f_exc, f_pc, f_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      exc_hold <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // After an excepting fetch, nothing more is taken until a redirect.
      if (push && f_exc) begin
        exc_hold <= 1'b1;
      end
    end
  end

endmodule
